// File: rtl/bus_drive_arbiter.sv
// Round-robin arbiter for a shared tri-state bus.
// One requester drives at a time. A tenure is capped at MAX_HOLD cycles
// only when someone else is waiting. Every hand-over, and every release
// to idle, inserts one dead cycle so two drivers never meet on the bus.
module bus_drive_arbiter #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output tri   [W-1:0]         bus
);

  localparam int OW = $clog2(N);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [OW-1:0] LAST_INIT = OW'(N - 1);
  localparam logic [N-1:0]  GNT_ONE   = N'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [N-1:0]    gnt_r, gnt_s;
  logic [OW-1:0]   owner_r, owner_s;
  logic            busy_r, busy_s;
  logic [HW-1:0]   hold_r, hold_s;
  logic [OW-1:0]   last_r, last_s;

  logic [OW-1:0]   win_s;
  logic            any_req_s;
  logic            others_s;
  logic [W-1:0]    slice_s [N];

  // First set request at or after (last + 1) mod N, wrapping around.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [OW-1:0] last);
    logic [OW-1:0] pick;
    logic [OW-1:0] cand;
    logic          found;
    pick  = {OW{1'b0}};
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand  = OW'((int'(last) + i) % N);
      pick  = (r[cand] && !found) ? cand : pick;
      found = found | r[cand];
    end
    return pick;
  endfunction

  assign win_s     = rr_pick(req, last_r);
  assign any_req_s = |req;
  // While driving, gnt_r is exactly the owner, so this is "anyone else waiting".
  assign others_s  = |(req & ~gnt_r);

  // Next-state and next-output decode for the IDLE/DRIVE/TURN controller.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    owner_s = owner_r;
    busy_s  = busy_r;
    hold_s  = hold_r;
    last_s  = last_r;
    case (state_r)
      IDLE, TURN: begin
        if (any_req_s) begin
          state_s = DRIVE;
          gnt_s   = GNT_ONE << win_s;
          owner_s = win_s;
          busy_s  = 1'b1;
          hold_s  = {HW{1'b0}};
          last_s  = win_s;
        end else begin
          state_s = IDLE;
          gnt_s   = {N{1'b0}};
          owner_s = {OW{1'b0}};
          busy_s  = 1'b0;
          hold_s  = {HW{1'b0}};
        end
      end
      DRIVE: begin
        if (!req[owner_r] || ((hold_r == HOLD_LAST) && others_s)) begin
          // Voluntary or forced release: one turnaround cycle follows.
          state_s = TURN;
          gnt_s   = {N{1'b0}};
          owner_s = {OW{1'b0}};
          busy_s  = 1'b0;
          hold_s  = {HW{1'b0}};
        end else if (hold_r == HOLD_LAST) begin
          // Nobody waiting: owner keeps the bus and a fresh hold window starts.
          hold_s = {HW{1'b0}};
        end else begin
          hold_s = hold_r + HOLD_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = {N{1'b0}};
        owner_s = {OW{1'b0}};
        busy_s  = 1'b0;
        hold_s  = {HW{1'b0}};
        last_s  = LAST_INIT;
      end
    endcase
  end

  // State, grant and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= {N{1'b0}};
      owner_r <= {OW{1'b0}};
      busy_r  <= 1'b0;
      hold_r  <= {HW{1'b0}};
      last_r  <= LAST_INIT;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      owner_r <= owner_s;
      busy_r  <= busy_s;
      hold_r  <= hold_s;
      last_r  <= last_s;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign slice_s[i] = data[i*W +: W];
  end

  assign gnt   = gnt_r;
  assign owner = owner_r;
  assign busy  = busy_r;
  // The data path is combinational, so mid-tenure data changes reach the bus at once.
  assign bus   = busy_r ? slice_s[owner_r] : {W{1'bz}};

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Bench for bus_drive_arbiter. A reference model that knows only
// "who owns the bus and for how long" predicts each cycle's outputs
// into a scoreboard queue. A monitor pops the queue and compares.
module tb_bus_drive_arbiter;

  localparam int N        = 4;
  localparam int W        = 32;
  localparam int MAX_HOLD = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy;
  wire  [W-1:0]   bus;

  bus_drive_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] gnt;
    int           owner;
    bit           busy;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   rand_data = 1'b0;
  int   obs_own[$];
  int   obs_len[$];

  // Reference model state: owner index (-1 means nobody drives).
  int   m_owner = -1;
  int   m_held  = 0;
  int   m_last  = N - 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input bit ok,
                     input logic [W-1:0] act, input logic [W-1:0] req_v);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req_v, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_bus(input exp_t e);
    if (e.busy) return data[e.owner*W +: W];
    return {W{1'bz}};
  endfunction

  // Reference model: a tenure ends when its owner drops the request, or
  // after each MAX_HOLD cycles if anyone else waits. A bus with no owner
  // (idle or just released) hands over to the next requester in rotation.
  initial begin
    forever begin
      exp_t e;
      bit   others;
      @(posedge clk);
      if (rst) begin
        m_owner = -1;
        m_held  = 0;
        m_last  = N - 1;
      end else if (m_owner >= 0) begin
        others = 1'b0;
        for (int j = 0; j < N; j++)
          if (j != m_owner && req[j]) others = 1'b1;
        if (!req[m_owner] || ((m_held % MAX_HOLD) == MAX_HOLD - 1 && others))
          m_owner = -1;
        else
          m_held++;
      end else if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_last = m_owner;
        m_held = 0;
      end
      e.busy  = (m_owner >= 0);
      e.owner = e.busy ? m_owner : 0;
      e.gnt   = e.busy ? N'(1 << m_owner) : '0;
      sb.push_back(e);
    end
  end

  // Monitor after each active edge: pop the prediction, compare, and log tenures.
  initial begin
    logic [N-1:0] prev_gnt;
    int           run;
    prev_gnt = '0;
    run      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 1'b0, W'(0), W'(1));
      end else begin
        cur      = sb.pop_front();
        have_cur = 1'b1;
        chk("gnt", gnt === cur.gnt, W'(gnt), W'(cur.gnt));
        chk("owner", owner === 2'(cur.owner), W'(owner), W'(cur.owner));
        chk("busy", busy === cur.busy, W'(busy), W'(cur.busy));
        chk("bus", bus === exp_bus(cur), bus, exp_bus(cur));
        chk("gnt_onehot0", $onehot0(gnt), W'(gnt), W'(0));
        if (gnt != '0 && gnt != prev_gnt) obs_own.push_back(int'(owner));
        if (gnt != '0) run++;
        if (gnt == '0 && prev_gnt != '0) begin
          obs_len.push_back(run);
          run = 0;
        end
        prev_gnt = gnt;
      end
    end
  end

  // Recheck the bus after data changes mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (have_cur) chk("bus_mid", bus === exp_bus(cur), bus, exp_bus(cur));
    end
  end

  task automatic drive(input logic r_rst, input logic [N-1:0] r_req, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r_rst;
      req = r_req;
      if (rand_data)
        for (int j = 0; j < N; j++) data[j*W +: W] = $urandom;
    end
  endtask

  task automatic do_rst();
    drive(1'b1, '0, 1);
    drive(1'b0, '0, 1);
    obs_own.delete();
    obs_len.delete();
  endtask

  initial begin
    int           exp_order[5] = '{0, 1, 2, 3, 0};
    int           fair_order[3] = '{2, 0, 2};
    logic [N-1:0] rq;
    rst  = 1'b1;
    req  = '0;
    data = '0;
    data[0 +: W] = W'(62143);

    // Single requester with fixed data.
    drive(1'b1, '0, 2);
    drive(1'b0, 4'b0001, 4);
    drive(1'b0, '0, 4);
    chk("single_len", obs_len.size() > 0 && obs_len[0] == 4,
        W'(obs_len.size() > 0 ? obs_len[0] : -1), W'(4));
    chk("single_own", obs_own.size() > 0 && obs_own[0] == 0,
        W'(obs_own.size() > 0 ? obs_own[0] : -1), W'(0));

    // All four requesting: strict rotation, 8-cycle tenures.
    rand_data = 1'b1;
    do_rst();
    drive(1'b0, 4'b1111, 46);
    drive(1'b0, '0, 3);
    for (int i = 0; i < 5; i++)
      chk("rr_order", obs_own.size() > i && obs_own[i] == exp_order[i],
          W'(obs_own.size() > i ? obs_own[i] : -1), W'(exp_order[i]));
    for (int i = 0; i < 4; i++)
      chk("rr_tenure", obs_len.size() > i && obs_len[i] == MAX_HOLD,
          W'(obs_len.size() > i ? obs_len[i] : -1), W'(MAX_HOLD));

    // Lone long owner: no forced release, one unbroken tenure.
    do_rst();
    drive(1'b0, 4'b0100, 20);
    drive(1'b0, '0, 3);
    chk("lone_len", obs_len.size() > 0 && obs_len[0] == 20,
        W'(obs_len.size() > 0 ? obs_len[0] : -1), W'(20));
    chk("lone_grants", obs_own.size() == 1, W'(obs_own.size()), W'(1));

    // Fairness: owner 2 forced off while 0 waits; 0 goes next, then 2.
    do_rst();
    drive(1'b0, 4'b0100, 2);
    drive(1'b0, 4'b0101, 30);
    drive(1'b0, '0, 3);
    for (int i = 0; i < 3; i++)
      chk("fair_order", obs_own.size() > i && obs_own[i] == fair_order[i],
          W'(obs_own.size() > i ? obs_own[i] : -1), W'(fair_order[i]));
    chk("fair_len", obs_len.size() > 0 && obs_len[0] == MAX_HOLD,
        W'(obs_len.size() > 0 ? obs_len[0] : -1), W'(MAX_HOLD));

    // Reset during owner 1's tenure, then arbitrate 1110 from scratch.
    do_rst();
    drive(1'b0, 4'b0010, 3);
    drive(1'b1, 4'b1110, 1);
    obs_own.delete();
    obs_len.delete();
    drive(1'b0, 4'b1110, 10);
    drive(1'b0, '0, 3);
    chk("rst_cut_len", obs_len.size() > 0 && obs_len[0] == 3,
        W'(obs_len.size() > 0 ? obs_len[0] : -1), W'(3));
    chk("rst_first", obs_own.size() > 0 && obs_own[0] == 1,
        W'(obs_own.size() > 0 ? obs_own[0] : -1), W'(1));

    // Random traffic with occasional resets.
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) rq = N'($urandom);
      drive($urandom_range(0, 99) == 0, rq, 1);
    end
    drive(1'b0, '0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
